golomb_result_streamer: RTL and testbench



---
 rtl/golomb_pkg.sv | 29 ++
 rtl/golomb_result_streamer_if.sv | 16 +
 rtl/golomb_result_mark_select.sv | 33 +++
 rtl/golomb_result_streamer.sv | 149 ++++++++++++++
 tb/tb_golomb_result_streamer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/golomb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : golomb_pkg
// Description : Shared constants, state encoding and bus-offset helper for the
//               Golomb result streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package golomb_pkg;

    localparam int MARKW = 9;
    localparam logic [7:0] HDR_TAG = 8'hA5;
    localparam logic [7:0] TRL_TAG = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_MARKS    = 3'd2,
        ST_TRAILER  = 3'd3,
        ST_WAIT_LOW = 3'd4
    } state_t;

    // LSB position of mark `mark` in 0-based slot `slot`; slot 0 / mark 0 sit at the MSB end.
    function automatic int bit_offset(input int slot, input int mark,
                                      input int num_positions, input int num_results);
        return (num_results * (num_positions + 1) - (slot * (num_positions + 1) + mark) - 1) * MARKW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/golomb_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : golomb_result_streamer_if
// Description : Valid/ready 16-bit word stream toward the host FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface golomb_result_streamer_if;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;

    modport master (input out_ready, output out_data, output out_valid, output out_last);
    modport slave  (output out_ready, input out_data, input out_valid, input out_last);
endinterface
`default_nettype wire

// File: rtl/golomb_result_mark_select.sv
`default_nettype none
// ============================================================================
// Module      : golomb_result_mark_select
// Description : Combinational pick of one 9-bit mark from the result snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module golomb_result_mark_select
    import golomb_pkg::*;
#(
    parameter int NUMPOSITIONS = 5,
    parameter int NUMRESULTS   = 10,
    parameter int SLOTW        = 4,
    parameter int MARKIDXW     = 3
) (
    input  wire logic [(NUMPOSITIONS+1)*MARKW*NUMRESULTS-1:0] i_snapshot,
    input  wire logic [SLOTW-1:0]                             i_slot,
    input  wire logic [MARKIDXW-1:0]                          i_mark,
    output logic      [MARKW-1:0]                             o_mark
);

    always_comb begin
        o_mark = '0;
        for (int s = 0; s < NUMRESULTS; s++) begin
            for (int m = 0; m <= NUMPOSITIONS; m++) begin
                if (i_slot == SLOTW'(s) && i_mark == MARKIDXW'(m)) begin
                    o_mark = i_snapshot[bit_offset(s, m, NUMPOSITIONS, NUMRESULTS) +: MARKW];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/golomb_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : golomb_result_streamer
// Description : Snapshots the ruler-search results on done and streams header,
//               marks and checksum trailer over a valid/ready word interface.
// Revision    : 1.0 - initial release
// ============================================================================
module golomb_result_streamer
    import golomb_pkg::*;
#(
    parameter int NUMPOSITIONS = 5,
    parameter int NUMRESULTS   = 10
) (
    input  wire logic                                         FXCLK,
    input  wire logic                                         RESET_IN,
    input  wire logic                                         done,
    input  wire logic [5:0]                                   numResults,
    input  wire logic [(NUMPOSITIONS+1)*MARKW*NUMRESULTS-1:0] results,
    golomb_result_streamer_if.master                          out_if,
    output logic                                              busy,
    output logic                                              overflow
);

    localparam int c_BUSW     = (NUMPOSITIONS + 1) * MARKW * NUMRESULTS;
    localparam int c_SLOTW    = (NUMRESULTS > 1) ? $clog2(NUMRESULTS) : 1;
    localparam int c_MARKIDXW = $clog2(NUMPOSITIONS + 1);
    localparam logic [c_MARKIDXW-1:0] c_LAST_MARK = c_MARKIDXW'(NUMPOSITIONS);
    localparam logic [5:0]            c_NR_MAX    = 6'(NUMRESULTS);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_armed;
    logic [c_BUSW-1:0]       r_snapshot;
    logic [5:0]              r_nr;
    logic [c_SLOTW-1:0]      r_slot;
    logic [c_MARKIDXW-1:0]   r_mark;
    logic [7:0]              r_checksum;
    logic                    r_busy;
    logic                    r_overflow;
    logic [MARKW-1:0]        w_mark;
    logic                    w_valid;
    logic                    w_last;
    logic [15:0]             w_data;
    logic                    w_fire;
    logic                    w_trigger;
    logic                    w_slot_end;
    logic                    w_stream_end;

    golomb_result_mark_select #(
        .NUMPOSITIONS (NUMPOSITIONS),
        .NUMRESULTS   (NUMRESULTS),
        .SLOTW        (c_SLOTW),
        .MARKIDXW     (c_MARKIDXW)
    ) u_mark_select (
        .i_snapshot (r_snapshot),
        .i_slot     (r_slot),
        .i_mark     (r_mark),
        .o_mark     (w_mark)
    );

    assign w_fire       = w_valid & out_if.out_ready;
    assign w_trigger    = (r_state == ST_IDLE) && done && r_armed;
    assign w_slot_end   = (r_mark == c_LAST_MARK);
    assign w_stream_end = w_slot_end && (6'(r_slot) == r_nr - 6'd1);

    always_ff @(posedge FXCLK) begin
        if (RESET_IN) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Outputs derive only from registers, so they hold steady while stalled.
    always_comb begin
        w_next_state = r_state;
        w_valid      = 1'b0;
        w_last       = 1'b0;
        w_data       = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) w_next_state = ST_HEADER;
            end
            ST_HEADER: begin
                w_valid = 1'b1;
                w_data  = {HDR_TAG, r_overflow, 1'b0, r_nr};
                if (w_fire) w_next_state = (r_nr == 6'd0) ? ST_TRAILER : ST_MARKS;
            end
            ST_MARKS: begin
                w_valid = 1'b1;
                w_data  = {7'b0, w_mark};
                if (w_fire && w_stream_end) w_next_state = ST_TRAILER;
            end
            ST_TRAILER: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                w_data  = {TRL_TAG, r_checksum};
                if (w_fire) w_next_state = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!done) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge FXCLK) begin
        if (w_trigger) r_snapshot <= results;
    end

    always_ff @(posedge FXCLK) begin
        if (RESET_IN) begin
            r_armed    <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_checksum <= 8'h00;
            r_nr       <= 6'd0;
            r_slot     <= '0;
            r_mark     <= '0;
        end else begin
            if (w_trigger) begin
                r_nr       <= (numResults > c_NR_MAX) ? c_NR_MAX : numResults;
                r_overflow <= (numResults > c_NR_MAX);
                r_armed    <= 1'b0;
                r_checksum <= 8'h00;
                r_busy     <= 1'b1;
                r_slot     <= '0;
                r_mark     <= '0;
            end
            if (r_state == ST_MARKS && w_fire) begin
                r_checksum <= r_checksum ^ w_mark[7:0];
                if (w_slot_end) begin
                    r_mark <= '0;
                    r_slot <= r_slot + c_SLOTW'(1);
                end else begin
                    r_mark <= r_mark + c_MARKIDXW'(1);
                end
            end
            if (r_state == ST_TRAILER && w_fire) r_busy <= 1'b0;
            // Re-arming happens only here, so done dropping mid-stream is ignored.
            if (r_state == ST_WAIT_LOW && !done) r_armed <= 1'b1;
        end
    end

    assign out_if.out_valid = w_valid;
    assign out_if.out_last  = w_last;
    assign out_if.out_data  = w_data;
    assign busy             = r_busy;
    assign overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_golomb_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_golomb_result_streamer
// Description : Directed self-checking bench for golomb_result_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_golomb_result_streamer;
    import golomb_pkg::*;

    localparam int NP   = 5;
    localparam int NR   = 10;
    localparam int BUSW = (NP + 1) * 9 * NR;

    logic            FXCLK = 1'b0;
    logic            RESET_IN;
    logic            done;
    logic [5:0]      numResults;
    logic [BUSW-1:0] results;
    logic            busy;
    logic            overflow;

    golomb_result_streamer_if sif ();

    golomb_result_streamer #(
        .NUMPOSITIONS (NP),
        .NUMRESULTS   (NR)
    ) dut (
        .FXCLK      (FXCLK),
        .RESET_IN   (RESET_IN),
        .done       (done),
        .numResults (numResults),
        .results    (results),
        .out_if     (sif),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 FXCLK = ~FXCLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  tb_marks [NR][NP+1];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_marks();
        for (int s = 0; s < NR; s++)
            for (int m = 0; m <= NP; m++) tb_marks[s][m] = 9'd0;
    endtask

    task automatic pack_results();
        results = '0;
        for (int s = 0; s < NR; s++)
            for (int m = 0; m <= NP; m++)
                results[BUSW-1-(s*(NP+1)+m)*9 -: 9] = tb_marks[s][m];
    endtask

    task automatic build_expected(input int nraw);
        int         nr;
        logic [7:0] cs;
        nr = (nraw > NR) ? NR : nraw;
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back({8'hA5, (nraw > NR) ? 1'b1 : 1'b0, 1'b0, 6'(nr)});
        for (int s = 0; s < nr; s++)
            for (int m = 0; m <= NP; m++) begin
                exp_q.push_back({7'b0, tb_marks[s][m]});
                cs = cs ^ tb_marks[s][m][7:0];
            end
        exp_q.push_back({8'h5A, cs});
    endtask

    // Re-arm (one cycle of done low), then raise done; returns at the negedge where the header should show.
    task automatic start_stream();
        done = 1'b0;
        @(negedge FXCLK);
        done = 1'b1;
        @(negedge FXCLK);
    endtask

    // Called at a negedge; consumes exp_q, checking each transferred word and stall stability.
    task automatic collect(input string tag, input bit bp, input int abort_at);
        int          idx;
        int          cycles;
        bit          stalled;
        logic [15:0] held;
        idx = 0; cycles = 0; stalled = 1'b0; held = '0;
        while (idx < exp_q.size()) begin
            if (cycles > 400) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s_timeout: observed %0d words expected %0d", tag, idx, exp_q.size());
                return;
            end
            if (stalled) begin
                check({tag, "_hold_valid"}, 16'(sif.out_valid), 16'h0001);
                check({tag, "_hold_data"}, sif.out_data, held);
            end
            if (sif.out_valid && idx == abort_at) begin
                sif.out_ready = 1'b0;
                RESET_IN      = 1'b1;
                return;
            end
            sif.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (sif.out_valid) begin
                if (sif.out_ready) begin
                    check({tag, "_data"}, sif.out_data, exp_q[idx]);
                    check({tag, "_last"}, 16'(sif.out_last), (idx == exp_q.size() - 1) ? 16'h0001 : 16'h0000);
                    idx++;
                end else begin
                    stalled = 1'b1;
                    held    = sif.out_data;
                end
            end
            @(negedge FXCLK);
            cycles++;
        end
        sif.out_ready = 1'b1;
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge FXCLK);
            if (sif.out_valid) seen++;
        end
        check(tag, 16'(seen), 16'h0000);
    endtask

    initial begin
        RESET_IN      = 1'b1;
        done          = 1'b0;
        numResults    = 6'd0;
        results       = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge FXCLK);
        check("rst_valid", 16'(sif.out_valid), 16'h0000);
        check("rst_last", 16'(sif.out_last), 16'h0000);
        check("rst_data", sif.out_data, 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        check("rst_ovf", 16'(overflow), 16'h0000);
        RESET_IN = 1'b0;
        @(negedge FXCLK);

        // Single result with header latency check
        clear_marks();
        tb_marks[0] = '{9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
        pack_results();
        numResults = 6'd1;
        exp_q = '{16'hA501, 16'h0000, 16'h0001, 16'h0004, 16'h000A, 16'h000C, 16'h0011, 16'h5A12};
        done = 1'b1;
        check("lat_pre_valid", 16'(sif.out_valid), 16'h0000);
        @(negedge FXCLK);
        check("lat_valid", 16'(sif.out_valid), 16'h0001);
        check("lat_busy", 16'(busy), 16'h0001);
        collect("single", 1'b0, -1);
        check("single_end_valid", 16'(sif.out_valid), 16'h0000);
        check("single_end_busy", 16'(busy), 16'h0000);
        check("single_ovf", 16'(overflow), 16'h0000);

        // done held high: no second stream; then one-cycle drop re-arms
        expect_quiet("hold_no_restream", 10);
        start_stream();
        check("rearm_hdr_valid", 16'(sif.out_valid), 16'h0001);
        collect("rearm", 1'b0, -1);

        // Back-pressure on the same data
        start_stream();
        collect("bp", 1'b1, -1);

        // Two results; inputs scrambled after the trigger edge
        tb_marks[1] = '{9'd0, 9'd1, 9'd4, 9'd10, 9'd15, 9'd17};
        pack_results();
        numResults = 6'd2;
        exp_q = '{16'hA502,
                  16'h0000, 16'h0001, 16'h0004, 16'h000A, 16'h000C, 16'h0011,
                  16'h0000, 16'h0001, 16'h0004, 16'h000A, 16'h000F, 16'h0011,
                  16'h5A03};
        start_stream();
        results    = ~results;
        numResults = 6'd0;
        collect("two", 1'b0, -1);

        // Overflow: 12 requested, 10 streamed
        for (int s = 0; s < NR; s++)
            for (int m = 0; m <= NP; m++) tb_marks[s][m] = 9'(s * 37 + m * 11 + 3);
        pack_results();
        numResults = 6'd12;
        build_expected(12);
        start_stream();
        check("ovf_hdr", sif.out_data, 16'hA58A);
        collect("ovf", 1'b0, -1);
        check("ovf_flag", 16'(overflow), 16'h0001);

        // Zero results
        numResults = 6'd0;
        exp_q = '{16'hA500, 16'h5A00};
        start_stream();
        collect("zero", 1'b0, -1);
        check("zero_ovf", 16'(overflow), 16'h0000);

        // Reset during the 4th mark word, done kept high
        clear_marks();
        tb_marks[0] = '{9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
        pack_results();
        numResults = 6'd1;
        exp_q = '{16'hA501, 16'h0000, 16'h0001, 16'h0004, 16'h000A, 16'h000C, 16'h0011, 16'h5A12};
        start_stream();
        collect("rst_pre", 1'b0, 4);
        @(negedge FXCLK);
        check("rst_mid_valid", 16'(sif.out_valid), 16'h0000);
        check("rst_mid_busy", 16'(busy), 16'h0000);
        RESET_IN      = 1'b0;
        sif.out_ready = 1'b1;
        @(negedge FXCLK);
        check("rst_restart_valid", 16'(sif.out_valid), 16'h0001);
        collect("rst_after", 1'b0, -1);
        expect_quiet("rst_single_stream", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
